// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and controller state type for the register file
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NREAD  = 2;
  localparam int DEF_NWRITE = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - bundled write/alloc/read port signals of the register file
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREAD  = DEF_NREAD,
  parameter int NWRITE = DEF_NWRITE
);

  logic                     ready;
  logic [NWRITE-1:0]        we;
  logic [NWRITE*ADDR_W-1:0] waddr;
  logic [NWRITE*DATA_W-1:0] wdata;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;
  logic [NREAD-1:0]         re;
  logic [NREAD*ADDR_W-1:0]  raddr;
  logic [NREAD*DATA_W-1:0]  rdata;
  logic [NREAD-1:0]         rvalid;

  modport master (
    input  ready, rdata, rvalid,
    output we, waddr, wdata, alloc_en, alloc_addr, re, raddr
  );

  modport slave (
    output ready, rdata, rvalid,
    input  we, waddr, wdata, alloc_en, alloc_addr, re, raddr
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending bits: set by alloc, cleared by writes, looked up per read port
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREAD  = DEF_NREAD,
  parameter int NWRITE = DEF_NWRITE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_en_i,
  input  logic [ADDR_W-1:0]        alloc_addr_i,
  input  logic [NWRITE-1:0]        wr_en_i,
  input  logic [NWRITE*ADDR_W-1:0] wr_addr_i,
  input  logic [NREAD*ADDR_W-1:0]  rd_addr_i,
  output logic [NREAD-1:0]         pend_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Writes retire pending entries; an alloc applied afterwards wins for the same address
  always_comb begin
    pend_d = pend_q;
    for (int k = 0; k < NWRITE; k++) begin
      if (wr_en_i[k]) begin
        pend_d[wr_addr_i[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (alloc_en_i && (alloc_addr_i != '0)) begin
      pend_d[alloc_addr_i] = 1'b1;
    end
  end

  // Pending state register, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  for (genvar j = 0; j < NREAD; j++) begin : g_lookup
    assign pend_o[j] = pend_q[rd_addr_i[j*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with clear sweep, bypass and pending tracking
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREAD  = DEF_NREAD,
  parameter int NWRITE = DEF_NWRITE
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              ready_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [NWRITE-1:0] wr_en;
  logic              alloc_ok;
  logic [NREAD-1:0]  pend;

  // Clear sweep controller: one entry per cycle, then READY until the next reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= CLEAR;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign alloc_ok  = ready_q & bus.alloc_en;

  // Writes only count once ready and never target the hardwired zero register
  for (genvar k = 0; k < NWRITE; k++) begin : g_wr
    assign wr_en[k] = ready_q & bus.we[k] & (bus.waddr[k*ADDR_W +: ADDR_W] != '0);
  end

  // Storage update: sweep zeroes during CLEAR, later ports override earlier ones in READY
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int k = 0; k < NWRITE; k++) begin
        if (wr_en[k]) begin
          mem_q[bus.waddr[k*ADDR_W +: ADDR_W]] <= bus.wdata[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREAD  (NREAD),
    .NWRITE (NWRITE)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .alloc_en_i   (alloc_ok),
    .alloc_addr_i (bus.alloc_addr),
    .wr_en_i      (wr_en),
    .wr_addr_i    (bus.waddr),
    .rd_addr_i    (bus.raddr),
    .pend_o       (pend)
  );

  for (genvar j = 0; j < NREAD; j++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rv;

    assign ra = bus.raddr[j*ADDR_W +: ADDR_W];

    // Read mux: stored value and pending status, overridden by same-cycle writes
    always_comb begin
      rd = '0;
      rv = 1'b0;
      if (ready_q && bus.re[j]) begin
        if (ra == '0) begin
          rv = 1'b1;
        end else begin
          rd = mem_q[ra];
          rv = ~pend[j];
          for (int k = 0; k < NWRITE; k++) begin
            if (wr_en[k] && (bus.waddr[k*ADDR_W +: ADDR_W] == ra)) begin
              rd = bus.wdata[k*DATA_W +: DATA_W];
              rv = 1'b1;
            end
          end
        end
      end
    end

    assign bus.rdata[j*DATA_W +: DATA_W] = rd;
    assign bus.rvalid[j]                 = rv;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_mp_if bus ();

  regfile_mp u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we         = '0;
    bus.waddr      = '0;
    bus.wdata      = '0;
    bus.alloc_en   = 1'b0;
    bus.alloc_addr = '0;
    bus.re         = '0;
    bus.raddr      = '0;
  endtask

  task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
    bus.we[port]            = 1'b1;
    bus.waddr[port*5 +: 5]  = a;
    bus.wdata[port*32 +: 32] = d;
  endtask

  task automatic rd(input int port, input logic [4:0] a);
    bus.re[port]           = 1'b1;
    bus.raddr[port*5 +: 5] = a;
  endtask

  task automatic wait_ready();
    cyc = 0;
    while (bus.ready !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    idle();
    rst = 1'b0;
    rd(0, 5'd3);
    rd(1, 5'd0);
    tick();
    tick();
    chk("reset_ready", {31'd0, bus.ready}, 32'd0);
    chk("reset_rdata0", bus.rdata[31:0], 32'd0);
    chk("reset_rvalid", {30'd0, bus.rvalid}, 32'd0);

    rst = 1'b1;
    wait_ready();
    chk("sweep_len", cyc, 32);
    idle();

    for (int a = 0; a < 32; a++) begin
      rd(0, 5'(a));
      rd(1, 5'(31 - a));
      #1;
      chk("clear_rdata0", bus.rdata[31:0], 32'd0);
      chk("clear_rdata1", bus.rdata[63:32], 32'd0);
      chk("clear_rvalid", {30'd0, bus.rvalid}, 32'd3);
    end

    idle();
    wr(0, 5'd7, 32'h1111_1111);
    wr(1, 5'd7, 32'h2222_2222);
    rd(0, 5'd7);
    rd(1, 5'd8);
    #1;
    chk("dual_wr_fwd", bus.rdata[31:0], 32'h2222_2222);
    chk("dual_wr_fwd_v", {31'd0, bus.rvalid[0]}, 32'd1);
    chk("other_port_rd", bus.rdata[63:32], 32'd0);
    tick();
    bus.we = '0;
    #1;
    chk("dual_wr_store", bus.rdata[31:0], 32'h2222_2222);

    idle();
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = 5'd9;
    tick();
    bus.alloc_en = 1'b0;
    rd(0, 5'd9);
    #1;
    chk("alloc_pend_v", {31'd0, bus.rvalid[0]}, 32'd0);
    chk("alloc_pend_d", bus.rdata[31:0], 32'd0);
    wr(0, 5'd9, 32'hDEAD_BEEF);
    #1;
    chk("wb_fwd_v", {31'd0, bus.rvalid[0]}, 32'd1);
    chk("wb_fwd_d", bus.rdata[31:0], 32'hDEAD_BEEF);
    tick();
    bus.we = '0;
    #1;
    chk("wb_after_v", {31'd0, bus.rvalid[0]}, 32'd1);
    chk("wb_after_d", bus.rdata[31:0], 32'hDEAD_BEEF);
    tick();
    chk("wb_later_v", {31'd0, bus.rvalid[0]}, 32'd1);

    bus.re[1]     = 1'b0;
    bus.raddr[9:5] = 5'd7;
    #1;
    chk("re_off_d", bus.rdata[63:32], 32'd0);
    chk("re_off_v", {31'd0, bus.rvalid[1]}, 32'd0);

    idle();
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = 5'd5;
    wr(0, 5'd5, 32'h0000_0055);
    rd(0, 5'd5);
    #1;
    chk("alloc_wr_fwd_d", bus.rdata[31:0], 32'h0000_0055);
    chk("alloc_wr_fwd_v", {31'd0, bus.rvalid[0]}, 32'd1);
    tick();
    bus.alloc_en = 1'b0;
    bus.we       = '0;
    #1;
    chk("alloc_wr_next_d", bus.rdata[31:0], 32'h0000_0055);
    chk("alloc_wr_next_v", {31'd0, bus.rvalid[0]}, 32'd0);
    wr(1, 5'd5, 32'h0000_0066);
    #1;
    chk("p1_clear_fwd", bus.rdata[31:0], 32'h0000_0066);
    tick();
    bus.we = '0;
    #1;
    chk("p1_clear_v", {31'd0, bus.rvalid[0]}, 32'd1);
    chk("p1_clear_d", bus.rdata[31:0], 32'h0000_0066);

    idle();
    wr(0, 5'd0, 32'hFFFF_FFFF);
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = 5'd0;
    rd(0, 5'd0);
    rd(1, 5'd0);
    #1;
    chk("zero_fwd_d", bus.rdata[31:0], 32'd0);
    chk("zero_fwd_v", {30'd0, bus.rvalid}, 32'd3);
    tick();
    bus.we       = '0;
    bus.alloc_en = 1'b0;
    #1;
    chk("zero_next_d", bus.rdata[63:32], 32'd0);
    chk("zero_next_v", {30'd0, bus.rvalid}, 32'd3);

    idle();
    wr(0, 5'd3, 32'h0000_000A);
    wr(1, 5'd4, 32'h0000_000B);
    rd(0, 5'd3);
    rd(1, 5'd4);
    #1;
    chk("split_fwd0", bus.rdata[31:0], 32'h0000_000A);
    chk("split_fwd1", bus.rdata[63:32], 32'h0000_000B);
    tick();
    bus.we = '0;
    #1;
    chk("split_st0", bus.rdata[31:0], 32'h0000_000A);
    chk("split_st1", bus.rdata[63:32], 32'h0000_000B);

    idle();
    rst = 1'b0;
    #1;
    chk("rst_async_ready", {31'd0, bus.ready}, 32'd0);
    tick();
    rst = 1'b1;
    repeat (10) tick();
    chk("mid_sweep_ready", {31'd0, bus.ready}, 32'd0);
    rst = 1'b0;
    rd(0, 5'd7);
    rd(1, 5'd9);
    #1;
    chk("mid_rst_rvalid", {30'd0, bus.rvalid}, 32'd0);
    tick();
    rst = 1'b1;
    wr(0, 5'd7, 32'h7777_7777);
    wr(1, 5'd9, 32'h9999_9999);
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = 5'd9;
    #1;
    chk("clear_rdata_gate", bus.rdata[31:0], 32'd0);
    wait_ready();
    chk("resweep_len", cyc, 32);
    bus.we       = '0;
    bus.alloc_en = 1'b0;
    #1;
    chk("clear_wr_ign7", bus.rdata[31:0], 32'd0);
    chk("clear_wr_ign9", bus.rdata[63:32], 32'd0);
    chk("clear_alloc_ign", {30'd0, bus.rvalid}, 32'd3);
    rd(0, 5'd3);
    rd(1, 5'd5);
    #1;
    chk("resweep_3", bus.rdata[31:0], 32'd0);
    chk("resweep_5", bus.rdata[63:32], 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
